// File: rtl/register_file_32.sv
// 32 x DATA_WIDTH register file, one sync write port, two async read ports.
// Optional same-cycle write-to-read forwarding: REGFILE_WRITE_BYPASS_EN.
module register_file_32 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeRegister,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB,
   output logic [31:0]           write_strobe
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREG];
   logic [NREG-1:0]       strobe;
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;

   // Enable gates the compare, so an X address with enable low yields 0.
   always_comb begin
      strobe = '0;
      for (int i = 0; i < NREG; i++) begin
         strobe[i] = ctrl_writeEnable &&
                     (ctrl_writeRegister == ADDR_WIDTH'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         write_strobe <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (strobe[i]) begin
               regs[i] <= data_writeReg;
            end
         end
         write_strobe <= 32'(strobe);
      end
   end

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (ctrl_readRegA != '0) begin
         rd_a = regs[ctrl_readRegA];
      end
      if (ctrl_readRegB != '0) begin
         rd_b = regs[ctrl_readRegB];
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic byp_ok;

   assign byp_ok = ctrl_writeEnable && !reset &&
                   (ctrl_writeRegister != '0);

   always_comb begin
      data_readRegA = rd_a;
      data_readRegB = rd_b;
      if (byp_ok && ctrl_readRegA == ctrl_writeRegister) begin
         data_readRegA = data_writeReg;
      end
      if (byp_ok && ctrl_readRegB == ctrl_writeRegister) begin
         data_readRegB = data_writeReg;
      end
   end
`else
   assign data_readRegA = rd_a;
   assign data_readRegB = rd_b;
`endif

endmodule
